ap_fifo_prefetch_nch: RTL and testbench
=======================================

# ap_fifo_prefetch_nch

Parametrised N-channel bridge from standard read-latency-1 FIFOs (`fifo_128x512` read side) to HLS `ap_fifo` consumer inputs (`in_r_dout`/`in_r_empty_n`/`in_r_read`). It replaces the per-channel single-register prefetch logic in the shell.
- Each channel has a 3-entry output buffer, so `src_rd_en` has no combinational path from `in_r_read` while still sustaining 1 word/cycle.
- Adds per-channel enable, flush, transfer counting and word-limit stop.
- Sits in the IP clock domain between each `fifo_to_function` instance and its HLS core.

## Interface
Parameters:
- `NCH`, 4: number of channels.
- `DW`, 128: data width per channel.
- `CW`, 32: counter/limit width.

Ports. Channel k occupies bits `[k*DW +: DW]` or `[k*CW +: CW]` of the packed buses.
- `ip_clk`  in  1  sole clock, rising edge.
- `ip_rst_n`  in  1  asynchronous, active-low reset.
- `src_empty`  in  NCH  source FIFO empty flags.
- `src_rd_en`  out  NCH  source FIFO read enables.
- `src_dout`  in  NCH*DW  source FIFO data, valid the cycle after `src_rd_en`.
- `in_r_dout`  out  NCH*DW  head-of-buffer word to the HLS core.
- `in_r_empty_n`  out  NCH  buffer holds at least one word.
- `in_r_read`  in  NCH  HLS pop request.
- `ch_en`  in  NCH  fetch enable per channel (level).
- `ch_flush`  in  NCH  single-cycle synchronous channel clear.
- `ch_limit`  in  NCH*CW  words to deliver; 0 = unlimited.
- `ch_count`  out  NCH*CW  words delivered since reset/flush.
- `ch_done`  out  NCH  limit reached.

## Operation
Per-channel state, all registered:
- `occ` 0..3: buffer occupancy.
- `infl` 1 bit: a read is in flight.
- `fcnt`: words fetched.
- `dcnt`: words delivered.
- buffer entries plus head pointer.

Fetch:
- `src_rd_en = ch_en & ~src_empty & ~ch_flush & ~fstop & (occ + infl < 3)`.
- `fstop = (ch_limit != 0) & (fcnt == ch_limit)`.
- `src_rd_en` depends only on registers and the listed inputs, never on `in_r_read`.
- `infl <= src_rd_en`.
- `fcnt` increments on `src_rd_en` and wraps at 2^CW.

Capture: when `infl` = 1, `src_dout` is written to the buffer tail.

Delivery:
- `in_r_empty_n = (occ != 0)`.
- `in_r_dout` = head entry.
- A pop is `in_r_read & in_r_empty_n`; it advances the head and increments `dcnt`.
- `in_r_read` while `in_r_empty_n` = 0 is ignored; no counter change.
- Capture and pop in the same cycle leave `occ` unchanged; FIFO order is preserved.
- `occ` never exceeds 3. This is guaranteed by the credit rule; overflow is a design error and is asserted in simulation.

Counters and done:
- `ch_count = dcnt`.
- `ch_done = (ch_limit != 0) & (dcnt == ch_limit)`.
- Once `fcnt` reaches the limit no further fetches occur, so `dcnt` stops at the limit.
- Changing `ch_limit` mid-run takes effect immediately in both comparisons.
- Software sets `ch_limit` only while the channel is idle or flushed.

`ch_en` deassert:
- Stops new fetches only.
- The in-flight word is still captured.
- Buffered words remain deliverable.

`ch_flush` (priority over everything in that channel):
- Next cycle: `occ` = 0, `fcnt` = `dcnt` = 0, `in_r_empty_n` = 0.
- A word whose `infl` was set in the flush cycle is discarded.
- `src_rd_en` = 0 during the flush cycle.
- Source FIFO contents are not touched; the shell resets that FIFO itself.

Channels are fully independent.

## Timing
Reset (async assert; release synchronous to `ip_clk` by the shell):
- `occ` = 0, `infl` = 0, `fcnt` = `dcnt` = 0.
- `src_rd_en` = 0 while `ip_rst_n` is low (gated).
- `in_r_empty_n` = 0, `in_r_dout` = 0, `ch_count` = 0, `ch_done` = 0.
- Reset mid-transfer discards the buffer and the in-flight word.

Latency and throughput:
- Empty buffer, `src_empty` falls in cycle t (with `ch_en` = 1): `src_rd_en` high in t, data captured at the end of t+1, `in_r_empty_n` = 1 in t+2.
- Steady state: 1 word/cycle with `in_r_read` held high (occ = 1, infl = 1 each cycle).
- HLS stall: at most 3 words buffered; `src_rd_en` drops in the cycle `occ + infl` reaches 3.
- `ch_count` and `ch_done` update the cycle after the pop.

## Test plan
- Streaming: source holds 0x1..0x40, `in_r_read` = 1 constantly → 64 words in order, one per cycle after the first at t+2; `ch_count` = 64; `src_rd_en` never high with `src_empty` = 1.
- Backpressure: `in_r_read` = 0 for 20 cycles with a full source → `occ` = 3, `src_rd_en` = 0 after 3 fetches; then `read` = 1 → no loss or duplication, order kept.
- Limit: `ch_limit` = 5, source holds 10 words → exactly 5 fetches and 5 pops; `ch_done` = 1 with `ch_count` = 5; 5 words remain in the source.
- Flush mid-stream: flush asserted while `occ` = 2 and `infl` = 1 → next cycle `in_r_empty_n` = 0, `ch_count` = 0; in-flight word never appears; later fetches deliver the following source word.
- Random per-channel `in_r_read`/`src_empty`/`ch_en` on 4 channels for 10k cycles versus a scoreboard → per-channel order intact, no cross-channel corruption; `ip_rst_n` pulsed mid-run → all outputs 0 immediately.

Source files
------------

// File: rtl/ap_fifo_prefetch_nch_if.sv
// Read-side FIFO and ap_fifo consumer signals for all channels, packed per channel.
// The master modport is the bridge; the slave modport is the shell/HLS side.
interface ap_fifo_prefetch_nch_if #(
  parameter int NCH = 4,
  parameter int DW  = 128
);
  logic [NCH-1:0]    src_empty;
  logic [NCH-1:0]    src_rd_en;
  logic [NCH*DW-1:0] src_dout;
  logic [NCH*DW-1:0] in_r_dout;
  logic [NCH-1:0]    in_r_empty_n;
  logic [NCH-1:0]    in_r_read;

  modport master (
    input  src_empty, src_dout, in_r_read,
    output src_rd_en, in_r_dout, in_r_empty_n
  );

  modport slave (
    output src_empty, src_dout, in_r_read,
    input  src_rd_en, in_r_dout, in_r_empty_n
  );
endinterface

// File: rtl/ap_fifo_prefetch_nch.sv
// N-channel latency-1 FIFO to ap_fifo bridge: 3-entry buffer per channel, first word visible 2 cycles after fetch.
// Fetch is credit-gated on occupancy + in-flight (never on in_r_read), so 1 word/cycle streams and stalls hold <= 3 words.
module ap_fifo_prefetch_nch #(
  parameter int NCH = 4,
  parameter int DW  = 128,
  parameter int CW  = 32
) (
  input  logic                ip_clk,
  input  logic                ip_rst_n,
  ap_fifo_prefetch_nch_if.master bus,
  input  logic [NCH-1:0]      ch_en,
  input  logic [NCH-1:0]      ch_flush,
  input  logic [NCH*CW-1:0]   ch_limit,
  output logic [NCH*CW-1:0]   ch_count,
  output logic [NCH-1:0]      ch_done
);

  logic [NCH-1:0]    rd_en_v;
  logic [NCH-1:0]    empty_n_v;
  logic [NCH*DW-1:0] dout_v;

  genvar k;
  generate
    for (k = 0; k < NCH; k++) begin : g_ch
      logic [1:0]    occ_q, occ_d;
      logic [1:0]    head_q, head_d;
      logic          infl_q;
      logic [CW-1:0] fcnt_q, fcnt_d;
      logic [CW-1:0] dcnt_q, dcnt_d;
      logic [DW-1:0] buf_q [3];
      logic [CW-1:0] lim;
      logic [2:0]    tail_sum, tail_wrap;
      logic [1:0]    tail;
      logic          flush, fstop, rd_en, pop;

      assign lim   = ch_limit[k*CW +: CW];
      assign flush = ch_flush[k];
      assign fstop = (lim != '0) && (fcnt_q == lim);
      // Gated by reset so the source FIFO is never popped while we are held in reset.
      assign rd_en = ip_rst_n & ch_en[k] & ~bus.src_empty[k] & ~flush & ~fstop
                   & (({1'b0, occ_q} + {2'b0, infl_q}) < 3'd3);
      assign pop   = bus.in_r_read[k] & (occ_q != 2'd0);

      assign tail_sum  = {1'b0, head_q} + {1'b0, occ_q};
      assign tail_wrap = tail_sum - 3'd3;
      assign tail      = (tail_sum >= 3'd3) ? tail_wrap[1:0] : tail_sum[1:0];

      always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        fcnt_d = fcnt_q;
        dcnt_d = dcnt_q;
        if (flush) begin
          occ_d  = 2'd0;
          head_d = 2'd0;
          fcnt_d = '0;
          dcnt_d = '0;
        end else begin
          occ_d = occ_q + {1'b0, infl_q} - {1'b0, pop};
          if (pop) begin
            head_d = (head_q == 2'd2) ? 2'd0 : head_q + 2'd1;
            dcnt_d = dcnt_q + CW'(1);
          end
          if (rd_en) begin
            fcnt_d = fcnt_q + CW'(1);
          end
        end
      end

      always_ff @(posedge ip_clk or negedge ip_rst_n) begin
        if (!ip_rst_n) begin
          occ_q  <= 2'd0;
          head_q <= 2'd0;
          infl_q <= 1'b0;
          fcnt_q <= '0;
          dcnt_q <= '0;
          for (int i = 0; i < 3; i++) buf_q[i] <= '0;
        end else begin
          occ_q  <= occ_d;
          head_q <= head_d;
          infl_q <= rd_en;
          fcnt_q <= fcnt_d;
          dcnt_q <= dcnt_d;
          // A word landing during a flush belongs to the discarded stream.
          if (infl_q && !flush) begin
            buf_q[tail] <= bus.src_dout[k*DW +: DW];
          end
        end
      end

      assign rd_en_v[k]            = rd_en;
      assign empty_n_v[k]          = (occ_q != 2'd0);
      assign dout_v[k*DW +: DW]    = buf_q[head_q];
      assign ch_count[k*CW +: CW]  = dcnt_q;
      assign ch_done[k]            = (lim != '0) && (dcnt_q == lim);

      a_no_overflow : assert property (@(posedge ip_clk) disable iff (!ip_rst_n)
        !(infl_q && !pop && !flush && (occ_q == 2'd3)));
    end
  endgenerate

  assign bus.src_rd_en    = rd_en_v;
  assign bus.in_r_empty_n = empty_n_v;
  assign bus.in_r_dout    = dout_v;

endmodule

// File: tb/tb_ap_fifo_prefetch_nch.sv
// Bench for ap_fifo_prefetch_nch: source FIFO model per channel feeds a per-channel
// expected-word queue that is popped and compared whenever the bridge delivers a word.
module tb_ap_fifo_prefetch_nch;
  localparam int NCH = 4;
  localparam int DW  = 128;
  localparam int CW  = 32;
  typedef logic [DW-1:0] word_t;

  logic              ip_clk = 1'b0;
  logic              ip_rst_n;
  logic [NCH-1:0]    ch_en, ch_flush, ch_done;
  logic [NCH*CW-1:0] ch_limit, ch_count;

  always #5 ip_clk = ~ip_clk;

  ap_fifo_prefetch_nch_if #(.NCH(NCH), .DW(DW)) bus ();

  ap_fifo_prefetch_nch #(.NCH(NCH), .DW(DW), .CW(CW)) dut (
    .ip_clk   (ip_clk),
    .ip_rst_n (ip_rst_n),
    .bus      (bus),
    .ch_en    (ch_en),
    .ch_flush (ch_flush),
    .ch_limit (ch_limit),
    .ch_count (ch_count),
    .ch_done  (ch_done)
  );

  int n_err = 0;
  int n_chk = 0;

  word_t          src_q [NCH][$];
  word_t          exp_q [NCH][$];
  word_t          pend [NCH];
  logic           infl_m [NCH];
  int             fcnt_m [NCH], dcnt_m [NCH], fetches [NCH], pops [NCH], seq [NCH];
  int             first_pop_cyc [NCH], last_pop_cyc [NCH];
  word_t          first_pop_val [NCH], last_pop_val [NCH];
  logic [NCH-1:0] en_r, flush_r, read_r, hold_r;
  logic [CW-1:0]  lim_r [NCH];
  int             cyc = 0;

  task automatic chk(string tag, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic word_t mkword(int k, int s);
    return {8'(k), 88'd0, 32'(s)};
  endfunction

  task automatic fill(int k, int n);
    repeat (n) begin
      seq[k]++;
      src_q[k].push_back(mkword(k, seq[k]));
    end
  endtask

  task automatic clear_model(int k);
    exp_q[k].delete();
    infl_m[k] = 1'b0;
    fcnt_m[k] = 0;
    dcnt_m[k] = 0;
  endtask

  task automatic reset_outputs_check();
    for (int k = 0; k < NCH; k++) begin
      chk("rst_rd_en",   {127'd0, bus.src_rd_en[k]}, '0);
      chk("rst_empty_n", {127'd0, bus.in_r_empty_n[k]}, '0);
      chk("rst_dout",    bus.in_r_dout[k*DW +: DW], '0);
      chk("rst_count",   {96'd0, ch_count[k*CW +: CW]}, '0);
      chk("rst_done",    {127'd0, ch_done[k]}, '0);
    end
  endtask

  // One clock: check registered outputs, drive inputs, then score what the next edge will do.
  task automatic tick();
    @(negedge ip_clk);
    cyc++;
    for (int k = 0; k < NCH; k++) begin
      chk("count", {96'd0, ch_count[k*CW +: CW]}, {96'd0, CW'(dcnt_m[k])});
      chk("done", {127'd0, ch_done[k]},
          {127'd0, (lim_r[k] != '0) && (lim_r[k] == CW'(dcnt_m[k]))});
    end
    for (int k = 0; k < NCH; k++) begin
      bus.src_dout[k*DW +: DW] = pend[k];
      bus.src_empty[k]         = (src_q[k].size() == 0) || hold_r[k];
      ch_limit[k*CW +: CW]     = lim_r[k];
    end
    ch_en         = en_r;
    ch_flush      = flush_r;
    bus.in_r_read = read_r;
    #1;
    for (int k = 0; k < NCH; k++) begin
      int   occ_m;
      logic fetch_exp;
      logic fetched;
      occ_m     = exp_q[k].size() - (infl_m[k] ? 1 : 0);
      fetch_exp = en_r[k] && !bus.src_empty[k] && !flush_r[k]
                  && !((lim_r[k] != '0) && (CW'(fcnt_m[k]) == lim_r[k]))
                  && (exp_q[k].size() < 3);
      chk("empty_n", {127'd0, bus.in_r_empty_n[k]}, {127'd0, occ_m != 0});
      chk("rd_en", {127'd0, bus.src_rd_en[k]}, {127'd0, fetch_exp});
      fetched = 1'b0;
      if (flush_r[k]) begin
        clear_model(k);
      end else begin
        if (read_r[k] && occ_m != 0) begin
          word_t w;
          w = exp_q[k].pop_front();
          chk("data", bus.in_r_dout[k*DW +: DW], w);
          dcnt_m[k]++;
          pops[k]++;
          if (first_pop_cyc[k] < 0) begin
            first_pop_cyc[k] = cyc;
            first_pop_val[k] = w;
          end
          last_pop_cyc[k] = cyc;
          last_pop_val[k] = w;
        end
        if (bus.src_rd_en[k] && src_q[k].size() > 0) begin
          pend[k] = src_q[k].pop_front();
          exp_q[k].push_back(pend[k]);
          fcnt_m[k]++;
          fetches[k]++;
          fetched = 1'b1;
        end
        infl_m[k] = fetched;
      end
    end
  endtask

  task automatic quiet_inputs();
    ch_en         = '0;
    ch_flush      = '0;
    bus.in_r_read = '0;
    bus.src_empty = '1;
  endtask

  task automatic pulse_reset();
    @(negedge ip_clk);
    #2 ip_rst_n = 1'b0;
    #1 reset_outputs_check();
    @(negedge ip_clk);
    quiet_inputs();
    ip_rst_n = 1'b1;
    for (int k = 0; k < NCH; k++) clear_model(k);
  endtask

  task automatic reset_stats(int k);
    fetches[k]       = 0;
    pops[k]          = 0;
    first_pop_cyc[k] = -1;
    last_pop_cyc[k]  = -1;
  endtask

  initial begin
    int fill_cyc;
    int total_pops;
    ip_rst_n = 1'b0;
    en_r = '0; flush_r = '0; read_r = '0; hold_r = '0;
    bus.src_dout = '0;
    ch_limit = '0;
    for (int k = 0; k < NCH; k++) begin
      lim_r[k] = '0;
      pend[k]  = '0;
      seq[k]   = 0;
      clear_model(k);
      reset_stats(k);
    end
    // Fetch conditions present while in reset: read enables must stay gated off.
    ch_en = '1; ch_flush = '0; bus.in_r_read = '1; bus.src_empty = '0;
    #3 reset_outputs_check();
    quiet_inputs();
    @(negedge ip_clk);
    ip_rst_n = 1'b1;

    // Streaming on channel 0: words 0x1..0x40, read held high.
    en_r[0] = 1'b1; read_r[0] = 1'b1;
    fill(0, 64);
    fill_cyc = cyc + 1;
    repeat (72) tick();
    chk("stream_pops", 128'(pops[0]), 128'd64);
    chk("stream_latency", 128'(first_pop_cyc[0]), 128'(fill_cyc + 2));
    chk("stream_rate", 128'(last_pop_cyc[0] - first_pop_cyc[0]), 128'd63);
    chk("stream_last", last_pop_val[0], 128'h40);
    chk("stream_count", {96'd0, ch_count[0 +: CW]}, 128'd64);
    en_r[0] = 1'b0; read_r[0] = 1'b0;

    // Backpressure on channel 1: no reads for 20 cycles, then drain.
    en_r[1] = 1'b1;
    fill(1, 30);
    repeat (20) tick();
    chk("bp_fetches", 128'(fetches[1]), 128'd3);
    chk("bp_rd_en", {127'd0, bus.src_rd_en[1]}, '0);
    chk("bp_empty_n", {127'd0, bus.in_r_empty_n[1]}, 128'd1);
    read_r[1] = 1'b1;
    repeat (40) tick();
    chk("bp_pops", 128'(pops[1]), 128'd30);
    chk("bp_last", last_pop_val[1], mkword(1, 30));
    en_r[1] = 1'b0; read_r[1] = 1'b0;

    // Word limit on channel 2.
    lim_r[2] = CW'(5);
    en_r[2] = 1'b1; read_r[2] = 1'b1;
    fill(2, 10);
    repeat (20) tick();
    chk("lim_fetches", 128'(fetches[2]), 128'd5);
    chk("lim_pops", 128'(pops[2]), 128'd5);
    chk("lim_done", {127'd0, ch_done[2]}, 128'd1);
    chk("lim_count", {96'd0, ch_count[2*CW +: CW]}, 128'd5);
    chk("lim_src_left", 128'(src_q[2].size()), 128'd5);
    en_r[2] = 1'b0; read_r[2] = 1'b0;
    flush_r[2] = 1'b1;
    tick();
    flush_r[2] = 1'b0;
    lim_r[2] = '0;
    tick();

    // Flush on channel 3 with two words buffered and one in flight.
    en_r[3] = 1'b1;
    fill(3, 20);
    repeat (3) tick();
    chk("fl_pre_empty_n", {127'd0, bus.in_r_empty_n[3]}, 128'd1);
    flush_r[3] = 1'b1;
    tick();
    flush_r[3] = 1'b0;
    read_r[3] = 1'b1;
    tick();
    chk("fl_empty_n", {127'd0, bus.in_r_empty_n[3]}, '0);
    chk("fl_count", {96'd0, ch_count[3*CW +: CW]}, '0);
    repeat (10) tick();
    chk("fl_next_word", first_pop_val[3], mkword(3, 4));
    en_r[3] = 1'b0; read_r[3] = 1'b0;

    // Random traffic on all channels with a reset pulse mid-run.
    for (int k = 0; k < NCH; k++) reset_stats(k);
    for (int i = 0; i < 10000; i++) begin
      for (int k = 0; k < NCH; k++) begin
        en_r[k]    = ($urandom_range(0, 9) != 0);
        read_r[k]  = ($urandom_range(0, 2) != 0);
        hold_r[k]  = ($urandom_range(0, 3) == 0);
        flush_r[k] = ($urandom_range(0, 299) == 0);
        if (src_q[k].size() < 4) fill(k, 8);
      end
      if (i == 5000) pulse_reset();
      tick();
    end

    en_r = '0; flush_r = '0; hold_r = '0; read_r = '1;
    repeat (10) tick();
    total_pops = 0;
    for (int k = 0; k < NCH; k++) begin
      chk("drain_empty_n", {127'd0, bus.in_r_empty_n[k]}, '0);
      total_pops += pops[k];
    end
    chk("rand_activity", {127'd0, total_pops > 4000}, 128'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
